// File: rtl/spram_fifo_ctrl_40bit.sv
// rtl/spram_fifo_ctrl_40bit.sv - valid/ready FIFO controller for a single-port 4096x40 RAM
// Optional almost_full flag: define SPRAM_FIFO_ALMOST_FULL_EN.
module spram_fifo_ctrl_40bit #(
  parameter int AWIDTH             = 12,
  parameter int NUM_WORDS          = 4096,
  parameter int DWIDTH             = 40,
  parameter int ALMOST_FULL_THRESH = 4064
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_data,
  input  logic [DWIDTH-1:0] ram_out,
  output logic [AWIDTH:0]   ram_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full
);

  localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH+1)'(NUM_WORDS);

  generate
    if (NUM_WORDS != (1 << AWIDTH) || ALMOST_FULL_THRESH > NUM_WORDS) begin : g_param_check
      $error("spram_fifo_ctrl_40bit: inconsistent depth parameters");
    end
  endgenerate

  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   count, count_next;
  logic              inflight;
  logic              last_grant;  // 1: read won the last contended cycle
  logic [DWIDTH-1:0] ob_mem [2];
  logic              ob_head, ob_tail;
  logic [1:0]        ob_cnt, occ;
  logic              rd_req, wr_req, contended, wr_grant, rd_grant, deq;

  // Reset gates the requests so every port takes its idle value while reset is high.
  assign occ       = ob_cnt + 2'(inflight);
  assign rd_req    = !reset && (count != '0) && (occ < 2'd2);
  assign wr_req    = !reset && in_valid && (count != FULL_COUNT);
  assign contended = rd_req && wr_req;
  assign wr_grant  = wr_req && (!rd_req || last_grant);
  assign rd_grant  = rd_req && !wr_grant;

  assign in_ready    = wr_grant;
  assign ram_wren    = wr_grant;
  assign ram_address = wr_grant ? wr_ptr : rd_ptr;
  assign ram_data    = wr_grant ? in_data : '0;

  assign out_valid = (ob_cnt != 2'd0);
  assign out_data  = out_valid ? ob_mem[ob_head] : '0;
  assign deq       = out_valid && out_ready;

  assign ram_count = count;
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0) && !inflight && (ob_cnt == 2'd0);

  always_comb begin
    count_next = count;
    if (wr_grant)
      count_next = count + (AWIDTH+1)'(1);
    else if (rd_grant)
      count_next = count - (AWIDTH+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      last_grant <= 1'b0;
      ob_head    <= 1'b0;
      ob_tail    <= 1'b0;
      ob_cnt     <= 2'd0;
    end else begin
      count    <= count_next;
      inflight <= rd_grant;
      if (wr_grant)
        wr_ptr <= wr_ptr + AWIDTH'(1);
      if (rd_grant)
        rd_ptr <= rd_ptr + AWIDTH'(1);
      if (contended)
        last_grant <= rd_grant;
      // The RAM holds its output during writes, so capture is valid under any grant.
      if (inflight)
        ob_tail <= ~ob_tail;
      if (deq)
        ob_head <= ~ob_head;
      ob_cnt <= ob_cnt + 2'(inflight) - 2'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (inflight)
      ob_mem[ob_tail] <= ram_out;
  end

`ifdef SPRAM_FIFO_ALMOST_FULL_EN
  localparam logic [AWIDTH:0] AF_THRESH = (AWIDTH+1)'(ALMOST_FULL_THRESH);
  logic af_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      af_q <= 1'b0;
    else
      af_q <= (count_next >= AF_THRESH);
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule
